// File: rtl/spi_display_arbiter.sv
// rtl/spi_display_arbiter.sv - packet-aware two-source arbiter in front of spi_display
// Optional fixed A-over-B priority: define SPI_DISPLAY_ARB_PRIO_EN.
module spi_display_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_dc,
    input  logic [7:0] a_data,
    output logic       a_get,
    input  logic       a_empty,
    input  logic       b_dc,
    input  logic [7:0] b_data,
    output logic       b_get,
    input  logic       b_empty,
    output logic       out_dc,
    output logic [7:0] out_data,
    input  logic       out_get,
    output logic       out_empty,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [7:0] HOLD_C = 8'(HOLD);

    state_t     state_q;
    logic       started_q;
    logic [7:0] hold_cnt_q;
    logic       last_q;

    logic   own_a, own_b;
    logic   cur_empty, cur_dc, oth_empty;
    logic   pop, may_switch, tie_to_a, boundary;
    state_t oth_state;

    assign own_a     = (state_q == OWN_A);
    assign own_b     = (state_q == OWN_B);
    assign cur_empty = own_b ? b_empty : a_empty;
    assign cur_dc    = own_b ? b_dc    : a_dc;
    assign oth_empty = own_b ? a_empty : b_empty;
    assign oth_state = own_b ? OWN_A   : OWN_B;

    always_comb begin
        busy      = own_a | own_b;
        owner     = own_b;
        out_empty = 1'b1;
        out_dc    = 1'b0;
        out_data  = 8'h00;
        if (own_a) begin
            out_empty = a_empty;
            out_dc    = a_dc;
            out_data  = a_data;
        end else if (own_b) begin
            out_empty = b_empty;
            out_dc    = b_dc;
            out_data  = b_data;
        end
    end

    assign pop   = out_get & busy & ~cur_empty;
    assign a_get = pop & own_a & ~reset;
    assign b_get = pop & own_b & ~reset;

`ifdef SPI_DISPLAY_ARB_PRIO_EN
    // A may only be pre-empted by itself; B yields at any command boundary.
    assign may_switch = own_b;
    assign tie_to_a   = 1'b1;
`else
    assign may_switch = 1'b1;
    assign tie_to_a   = last_q;
`endif

    // A command head after at least one pop marks the end of the owner's packet.
    assign boundary = ~cur_empty & ~cur_dc & started_q & ~oth_empty & may_switch;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            started_q  <= 1'b0;
            hold_cnt_q <= 8'd0;
            last_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    started_q  <= 1'b0;
                    hold_cnt_q <= 8'd0;
                    if (!a_empty && (b_empty || tie_to_a)) begin
                        state_q <= OWN_A;
                    end else if (!b_empty) begin
                        state_q <= OWN_B;
                    end
                end
                OWN_A, OWN_B: begin
                    if (pop) begin
                        started_q  <= 1'b1;
                        hold_cnt_q <= 8'd0;
                    end else if (boundary) begin
                        state_q    <= oth_state;
                        started_q  <= 1'b0;
                        hold_cnt_q <= 8'd0;
                        last_q     <= own_b;
                    end else if (cur_empty && (hold_cnt_q < HOLD_C)) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end else if (cur_empty) begin
                        state_q    <= oth_empty ? IDLE : oth_state;
                        started_q  <= 1'b0;
                        hold_cnt_q <= 8'd0;
                        last_q     <= own_b;
                    end else begin
                        hold_cnt_q <= 8'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_arbiter.sv
// tb/tb_spi_display_arbiter.sv - directed self-checking bench for spi_display_arbiter
module tb_spi_display_arbiter;

    localparam int HOLD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_dc = 1'b0, b_dc = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_empty = 1'b1, b_empty = 1'b1;
    logic       a_get, b_get;
    logic       out_dc, out_empty, out_get = 1'b0;
    logic [7:0] out_data;
    logic       busy, owner;

    logic [8:0]  qa[$], qb[$];
    logic [10:0] log_q[$], exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt;

    spi_display_arbiter #(.HOLD(HOLD)) dut (
        .clock(clock), .reset(reset),
        .a_dc(a_dc), .a_data(a_data), .a_get(a_get), .a_empty(a_empty),
        .b_dc(b_dc), .b_data(b_data), .b_get(b_get), .b_empty(b_empty),
        .out_dc(out_dc), .out_data(out_data), .out_get(out_get), .out_empty(out_empty),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source FIFOs and spi_display sink; heads update after the edge so the DUT sees stable inputs.
    always @(posedge clock) begin
        if (out_get && !out_empty) log_q.push_back({b_get, a_get, out_dc, out_data});
        if (a_get && qa.size() > 0) begin
            check("route_a", {23'd0, out_dc, out_data}, {23'd0, qa[0]});
            void'(qa.pop_front());
        end
        if (b_get && qb.size() > 0) begin
            check("route_b", {23'd0, out_dc, out_data}, {23'd0, qb[0]});
            void'(qb.pop_front());
        end
        a_empty <= (qa.size() == 0);
        a_dc    <= (qa.size() > 0) ? qa[0][8]   : 1'b0;
        a_data  <= (qa.size() > 0) ? qa[0][7:0] : 8'h00;
        b_empty <= (qb.size() == 0);
        b_dc    <= (qb.size() > 0) ? qb[0][8]   : 1'b0;
        b_data  <= (qb.size() > 0) ? qb[0][7:0] : 8'h00;
    end

    function automatic logic [10:0] ea(input logic [8:0] it);
        return {2'b01, it};
    endfunction

    function automatic logic [10:0] eb(input logic [8:0] it);
        return {2'b10, it};
    endfunction

    task automatic clear_and_reset();
        @(negedge clock);
        reset   = 1'b1;
        out_get = 1'b0;
        qa.delete();
        qb.delete();
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One out_get pulse every 4 cycles until n items have been delivered.
    task automatic pump(input int n);
        int it = 0;
        while (log_q.size() < n && it < 200) begin
            @(negedge clock);
            out_get = 1'b1;
            @(negedge clock);
            out_get = 1'b0;
            if (log_q.size() < n) repeat (2) @(negedge clock);
            it++;
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check(tag, {21'd0, log_q[i]}, {21'd0, exp_q[i]});
    endtask

    initial begin
        // Reset with both sources loaded and out_get asserted.
        clear_and_reset();
        qa.push_back(9'h02A);
        qb.push_back(9'h02C);
        out_get = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_a_get", a_get, 1'b0);
        check("rst_b_get", b_get, 1'b0);
        check("rst_out_empty", out_empty, 1'b1);
        check("rst_busy", busy, 1'b0);
        out_get = 1'b0;
        reset   = 1'b0;
        check("rst_idle_first", busy, 1'b0);
        @(negedge clock);
        check("rst_grant_busy", busy, 1'b1);
        check("rst_grant_owner", owner, 1'b0);
        check("rst_grant_nonempty", out_empty, 1'b0);

        // Single source, then HOLD+1 empty cycles of grant with out_get held high.
        clear_and_reset();
        qa.push_back(9'h02A); qa.push_back(9'h100); qa.push_back(9'h13F);
        release_reset();
        pump(3);
        out_get = 1'b1;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        out_get = 1'b0;
        check("single_hold", cnt, HOLD + 1);
        exp_q = '{ea(9'h02A), ea(9'h100), ea(9'h13F)};
        check_log("single_log");

        // Boundary switch between packets.
        clear_and_reset();
        qa.push_back(9'h02A); qa.push_back(9'h100); qa.push_back(9'h13F); qa.push_back(9'h02B);
        qb.push_back(9'h02C); qb.push_back(9'h1FF);
        release_reset();
        pump(6);
`ifdef SPI_DISPLAY_ARB_PRIO_EN
        exp_q = '{ea(9'h02A), ea(9'h100), ea(9'h13F), ea(9'h02B), eb(9'h02C), eb(9'h1FF)};
`else
        exp_q = '{ea(9'h02A), ea(9'h100), ea(9'h13F), eb(9'h02C), eb(9'h1FF), ea(9'h02B)};
`endif
        check_log("boundary_log");

        // A stalls 3 cycles mid-packet while B waits.
        clear_and_reset();
        qa.push_back(9'h02A); qa.push_back(9'h100);
        qb.push_back(9'h02C); qb.push_back(9'h1FF);
        release_reset();
        pump(2);
        repeat (2) @(negedge clock);
        qa.push_back(9'h155);
        check("stall_in_owner", owner, 1'b0);
        check("stall_in_busy", busy, 1'b1);
        pump(5);
        exp_q = '{ea(9'h02A), ea(9'h100), ea(9'h155), eb(9'h02C), eb(9'h1FF)};
        check_log("stall_in_log");

        // A stalls past HOLD: B takes over on the (HOLD+1)th empty cycle.
        clear_and_reset();
        qa.push_back(9'h02A); qa.push_back(9'h100);
        qb.push_back(9'h02C); qb.push_back(9'h1FF);
        release_reset();
        pump(2);
        cnt = 0;
        while (busy && owner == 1'b0 && cnt < 10) begin
            cnt++;
            @(negedge clock);
        end
        check("stall_out_switch", cnt, HOLD + 1);
        check("stall_out_owner", owner, 1'b1);
        qa.push_back(9'h155);
        pump(5);
        exp_q = '{ea(9'h02A), ea(9'h100), eb(9'h02C), eb(9'h1FF), ea(9'h155)};
        check_log("stall_out_log");

        // B owns; A arrives mid-packet and takes over at B's next command head.
        clear_and_reset();
        qb.push_back(9'h02C); qb.push_back(9'h1FF); qb.push_back(9'h02D); qb.push_back(9'h1EE);
        release_reset();
        pump(1);
        qa.push_back(9'h02B);
        pump(5);
        exp_q = '{eb(9'h02C), eb(9'h1FF), ea(9'h02B), eb(9'h02D), eb(9'h1EE)};
        check_log("takeover_log");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
